// File: rtl/spi_cfg_pkg.sv
// Shared SPI config-link definitions: command bytes, frame lengths, FSM encoding.
// Macro SPI_CFG_HOST_WTAIL_EN lengthens write frames by one trailing 0x00 byte.
package spi_cfg_pkg;

    localparam logic [7:0] CMD_WRITE = 8'h01;
    localparam logic [7:0] CMD_READ  = 8'h02;

    localparam int unsigned RD_FRAME_BYTES = 9;
`ifdef SPI_CFG_HOST_WTAIL_EN
    localparam int unsigned WR_FRAME_BYTES = 11;
`else
    localparam int unsigned WR_FRAME_BYTES = 10;
`endif
    localparam int unsigned MAX_FRAME_BYTES = 11;
    localparam int unsigned RD_DATA_BYTE0   = 5;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_CS_SETUP = 3'd1,
        ST_SHIFT    = 3'd2,
        ST_CS_HOLD  = 3'd3,
        ST_CS_GAP   = 3'd4
    } spi_state_e;

    // Byte at position idx of a frame; anything past the end of a frame is 0x00.
    function automatic logic [7:0] frame_byte(input logic [3:0]  idx,
                                              input logic        we,
                                              input logic [31:0] addr,
                                              input logic [31:0] wdata);
        logic [7:0] b;
        b = 8'h00;
        case (idx)
            4'd0:    b = we ? CMD_WRITE : CMD_READ;
            4'd1:    b = addr[7:0];
            4'd2:    b = addr[15:8];
            4'd3:    b = addr[23:16];
            4'd4:    b = addr[31:24];
            4'd6:    b = we ? wdata[7:0]   : 8'h00;
            4'd7:    b = we ? wdata[15:8]  : 8'h00;
            4'd8:    b = we ? wdata[23:16] : 8'h00;
            4'd9:    b = we ? wdata[31:24] : 8'h00;
            default: b = 8'h00;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/spi_cfg_sck_gen.sv
// SCK divider: toggles SCK every SCK_DIV cycles while enabled, flagging the cycle
// before each rising/falling edge so the FSM can act on the same clock edge.
module spi_cfg_sck_gen #(
    parameter int unsigned SCK_DIV = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic sck,
    output logic rise,
    output logic fall
);

    logic [7:0] div_cnt_q, div_cnt_d;
    logic       sck_q, sck_d;
    logic       tick;

    assign tick = en && (div_cnt_q == 8'(SCK_DIV - 1));
    assign rise = tick && !sck_q;
    assign fall = tick && sck_q;
    assign sck  = sck_q;

    always_comb begin
        div_cnt_d = div_cnt_q;
        sck_d     = sck_q;
        if (!en) begin
            div_cnt_d = '0;
            sck_d     = 1'b0;
        end else if (tick) begin
            div_cnt_d = '0;
            sck_d     = !sck_q;
        end else begin
            div_cnt_d = div_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt_q <= '0;
            sck_q     <= 1'b0;
        end else begin
            div_cnt_q <= div_cnt_d;
            sck_q     <= sck_d;
        end
    end

endmodule

// File: rtl/spi_cfg_host.sv
// SPI mode-0 master turning host read/write requests into config-link frames.
// Define SPI_CFG_HOST_WTAIL_EN to append a trailing 0x00 byte to write frames.
module spi_cfg_host
    import spi_cfg_pkg::*;
#(
    parameter int unsigned SCK_DIV = 2
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_n_i,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        spi_sck,
    output logic        spi_mosi,
    output logic        spi_cs_n,
    input  logic        spi_miso
);

    spi_state_e  state_q, state_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d, wdata_q, wdata_d;
    logic [31:0] rx_q, rx_d, rdata_q, rdata_d;
    logic [7:0]  sh_q, sh_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [3:0]  byte_cnt_q, byte_cnt_d;
    logic [8:0]  tmr_q, tmr_d;
    logic        cs_n_q, cs_n_d, ready_q, ready_d, rsp_valid_q, rsp_valid_d;
    logic [3:0]  last_byte;
    logic [1:0]  rx_byte;
    logic        sck_en, sck_rise, sck_fall;

    assign sck_en = (state_q == ST_CS_SETUP) || (state_q == ST_SHIFT);

    spi_cfg_sck_gen #(.SCK_DIV(SCK_DIV)) u_sck_gen (
        .clk  (wb_clk_i),
        .rst_n(wb_rst_n_i),
        .en   (sck_en),
        .sck  (spi_sck),
        .rise (sck_rise),
        .fall (sck_fall)
    );

    assign last_byte = we_q ? 4'(WR_FRAME_BYTES - 1) : 4'(RD_FRAME_BYTES - 1);
    assign rx_byte   = 2'(byte_cnt_q - 4'(RD_DATA_BYTE0));

    always_comb begin
        state_d     = state_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rx_d        = rx_q;
        rdata_d     = rdata_q;
        sh_d        = sh_q;
        bit_cnt_d   = bit_cnt_q;
        byte_cnt_d  = byte_cnt_q;
        tmr_d       = tmr_q;
        rsp_valid_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_valid && ready_q) begin
                    state_d    = ST_CS_SETUP;
                    we_d       = req_we;
                    addr_d     = req_addr;
                    wdata_d    = req_wdata;
                    sh_d       = req_we ? CMD_WRITE : CMD_READ;
                    bit_cnt_d  = '0;
                    byte_cnt_d = '0;
                end
            end
            ST_CS_SETUP: begin
                if (sck_rise) state_d = ST_SHIFT;
            end
            ST_SHIFT: begin
                // MISO and MOSI both move on the falling edge of SCK.
                if (sck_fall) begin
                    if (!we_q && byte_cnt_q >= 4'(RD_DATA_BYTE0))
                        rx_d[{rx_byte, ~bit_cnt_q}] = spi_miso;
                    if (bit_cnt_q == 3'd7) begin
                        bit_cnt_d  = '0;
                        byte_cnt_d = byte_cnt_q + 4'd1;
                        sh_d       = frame_byte(byte_cnt_q + 4'd1, we_q, addr_q, wdata_q);
                        if (byte_cnt_q == last_byte) begin
                            state_d = ST_CS_HOLD;
                            tmr_d   = '0;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        sh_d      = {sh_q[6:0], 1'b0};
                    end
                end
            end
            ST_CS_HOLD: begin
                if (tmr_q == 9'(SCK_DIV - 1)) begin
                    state_d     = ST_CS_GAP;
                    tmr_d       = '0;
                    rsp_valid_d = 1'b1;
                    if (!we_q) rdata_d = rx_q;
                end else begin
                    tmr_d = tmr_q + 9'd1;
                end
            end
            ST_CS_GAP: begin
                if (tmr_q == 9'(2 * SCK_DIV - 1)) begin
                    state_d = ST_IDLE;
                    tmr_d   = '0;
                end else begin
                    tmr_d = tmr_q + 9'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        cs_n_d  = (state_d == ST_IDLE) || (state_d == ST_CS_GAP);
        ready_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            state_q     <= ST_IDLE;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rx_q        <= '0;
            rdata_q     <= '0;
            sh_q        <= '0;
            bit_cnt_q   <= '0;
            byte_cnt_q  <= '0;
            tmr_q       <= '0;
            cs_n_q      <= 1'b1;
            ready_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rx_q        <= rx_d;
            rdata_q     <= rdata_d;
            sh_q        <= sh_d;
            bit_cnt_q   <= bit_cnt_d;
            byte_cnt_q  <= byte_cnt_d;
            tmr_q       <= tmr_d;
            cs_n_q      <= cs_n_d;
            ready_q     <= ready_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end

    assign req_ready = ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rdata_q;
    assign spi_mosi  = sh_q[7];
    assign spi_cs_n  = cs_n_q;

endmodule
